// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer engine: FSM state encoding and default widths.
package dma_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_LEN_W   = 10;
   localparam int DEF_TMO_CYC = 1023;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_CAPT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } dma_state_e;

endpackage

// File: rtl/dma_xfer_cnt.sv
// Address and remaining-word registers for one DMA transfer: load at start, step per accepted write.
module dma_xfer_cnt
   import dma_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [LEN_W-1:0]  rem_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;

   // Address wraps naturally modulo 2^ADDR_W.
   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = base_i;
         rem_d  = len_i;
      end else if (step_i) begin
         addr_d = addr_q + 1'b1;
         rem_d  = rem_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign addr_o = addr_q;
   assign rem_o  = rem_q;
   assign last_o = (rem_q == LEN_W'(1));

endmodule

// File: rtl/dma_xfer_engine.sv
// FIFO-to-memory DMA engine: pop, capture, write one word at a time until the length is exhausted.
// Optional FIFO-starve timeout in POP is built when DMA_XFER_TIMEOUT_EN is defined.
module dma_xfer_engine
   import dma_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int TMO_CYC = DEF_TMO_CYC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              DMA_Enable_i,
   input  logic              DMA_REQ_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [LEN_W-1:0]  xfer_len_i,
   input  logic [DATA_W-1:0] fifo_data_i,
   input  logic              fifo_empty_i,
   output logic              fifo_rd_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ready_i,
   output logic              DMA_Active_o,
   output logic              ASSP_DMA_Done_o,
   output logic              dma_err_o,
   output dma_state_e        dbg_state_o
);

   // Memory handshake: mem_wr_o is held with stable addr/data until a cycle with mem_ready_i=1.

   dma_state_e        state_q, state_d;
   logic              active_q, active_d;
   logic              err_q, err_d;
   logic              abort_q, abort_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              cnt_load, cnt_step, cnt_last;
   logic [ADDR_W-1:0] cnt_addr;
   logic [LEN_W-1:0]  cnt_rem;
   logic              fifo_rd, done;
   logic              tmo_hit;

   dma_xfer_cnt #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (cnt_load),
      .step_i (cnt_step),
      .base_i (base_addr_i),
      .len_i  (xfer_len_i),
      .addr_o (cnt_addr),
      .rem_o  (cnt_rem),
      .last_o (cnt_last)
   );

`ifdef DMA_XFER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);
   logic [TMO_W-1:0] tmo_q;

   // Counts consecutive starved POP cycles; any pop or leaving POP restarts it.
   always_ff @(posedge clk_i) begin
      if (rst_i || state_q != ST_POP || !fifo_empty_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end

   assign tmo_hit = (state_q == ST_POP) && fifo_empty_i && (tmo_q == TMO_W'(TMO_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      abort_d  = abort_q;
      data_d   = data_q;
      cnt_load = 1'b0;
      cnt_step = 1'b0;
      fifo_rd  = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (DMA_REQ_i && DMA_Enable_i) begin
               cnt_load = 1'b1;
               err_d    = 1'b0;
               state_d  = (xfer_len_i == '0) ? ST_DONE : ST_POP;
            end
         end
         ST_POP: begin
            if (!DMA_Enable_i) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (!fifo_empty_i) begin
               fifo_rd = 1'b1;
               state_d = ST_CAPT;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_CAPT: begin
            data_d  = fifo_data_i;
            state_d = ST_WRITE;
            if (!DMA_Enable_i) abort_d = 1'b1;
         end
         ST_WRITE: begin
            if (!DMA_Enable_i) abort_d = 1'b1;
            if (mem_ready_i) begin
               cnt_step = 1'b1;
               if (abort_q || !DMA_Enable_i) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (cnt_last) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_POP;
               end
            end
         end
         ST_DONE: begin
            // A zero-length transfer arrives here with Active still high; hold one cycle so they never overlap.
            if (!active_q) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      active_d = (state_d == ST_POP) || (state_d == ST_CAPT) || (state_d == ST_WRITE) ||
                 ((state_q == ST_IDLE) && (state_d == ST_DONE));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         active_q <= 1'b0;
         err_q    <= 1'b0;
         abort_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         err_q    <= err_d;
         abort_q  <= abort_d;
         data_q   <= data_d;
      end
   end

   assign fifo_rd_o       = fifo_rd;
   assign mem_wr_o        = (state_q == ST_WRITE);
   assign mem_addr_o      = cnt_addr;
   assign mem_data_o      = data_q;
   assign DMA_Active_o    = active_q;
   assign ASSP_DMA_Done_o = done;
   assign dma_err_o       = err_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine: expected writes queued at stimulus, a negedge monitor pops and compares.
module tb_dma_xfer_engine;
   import dma_pkg::*;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          DMA_Enable_i = 1'b0;
   logic          DMA_REQ_i = 1'b0;
   logic [AW-1:0] base_addr_i = '0;
   logic [LW-1:0] xfer_len_i = '0;
   logic [DW-1:0] fifo_data_i = '0;
   logic          fifo_empty_i = 1'b0;
   logic          fifo_rd_o, mem_wr_o, mem_ready_i;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o;
   logic          DMA_Active_o, ASSP_DMA_Done_o, dma_err_o;
   dma_state_e    dbg_state_o;

   always #5 clk = ~clk;

   dma_xfer_engine #(
      .DATA_W (DW), .ADDR_W (AW), .LEN_W (LW), .TMO_CYC (1023)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .DMA_Enable_i    (DMA_Enable_i),
      .DMA_REQ_i       (DMA_REQ_i),
      .base_addr_i     (base_addr_i),
      .xfer_len_i      (xfer_len_i),
      .fifo_data_i     (fifo_data_i),
      .fifo_empty_i    (fifo_empty_i),
      .fifo_rd_o       (fifo_rd_o),
      .mem_wr_o        (mem_wr_o),
      .mem_addr_o      (mem_addr_o),
      .mem_data_o      (mem_data_o),
      .mem_ready_i     (mem_ready_i),
      .DMA_Active_o    (DMA_Active_o),
      .ASSP_DMA_Done_o (ASSP_DMA_Done_o),
      .dma_err_o       (dma_err_o),
      .dbg_state_o     (dbg_state_o)
   );

   int total = 0;
   int bad = 0;
   logic [AW+DW-1:0] exp_q[$];

   // Cumulative event counters owned by the monitor; tests work on deltas.
   int wr_cnt = 0, rd_cnt = 0, act_cnt = 0, done_cnt = 0;
   int overlap_cnt = 0, extra_wr = 0;
   logic [DW-1:0] fifo_seq = 32'hC0DE_0000;
   int stall_word = -1, stall_len = 0, stall_used = 0;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // FIFO model (data valid the cycle after the pop) and memory ready driver.
   always @(negedge clk) begin
      if (fifo_rd_o) begin
         fifo_data_i = fifo_seq;
         fifo_seq = fifo_seq + 1'b1;
      end
      mem_ready_i = 1'b1;
      if (mem_wr_o && wr_cnt == stall_word && stall_used < stall_len) begin
         mem_ready_i = 1'b0;
         stall_used++;
      end
   end

   // Monitor: samples after the inputs for the coming edge have settled.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      #1;
      if (DMA_Active_o) act_cnt++;
      if (ASSP_DMA_Done_o) done_cnt++;
      if (fifo_rd_o) rd_cnt++;
      if (DMA_Active_o && ASSP_DMA_Done_o) overlap_cnt++;
      if (prev_stall && mem_wr_o) begin
         check("stall_addr", mem_addr_o, prev_addr);
         check("stall_data", mem_data_o, prev_data);
      end
      prev_stall = mem_wr_o && !mem_ready_i;
      prev_addr  = mem_addr_o;
      prev_data  = mem_data_o;
      if (mem_wr_o && mem_ready_i) begin
         if (exp_q.size() == 0) begin
            extra_wr++;
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr_o, e[AW+DW-1:DW]);
            check("wr_data", mem_data_o, e[DW-1:0]);
         end
         wr_cnt++;
      end
   end

   task automatic push_exp(input logic [AW-1:0] base, input logic [DW-1:0] seq0, input int n);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int i = 0; i < n; i++) begin
         a = base + AW'(i);
         d = seq0 + DW'(i);
         exp_q.push_back({a, d});
      end
   endtask

   task automatic start(input logic [AW-1:0] base, input logic [LW-1:0] len, input bit hold);
      @(negedge clk);
      base_addr_i = base;
      xfer_len_i  = len;
      DMA_REQ_i   = 1'b1;
      if (!hold) begin
         @(negedge clk);
         DMA_REQ_i = 1'b0;
      end
   endtask

   task automatic wait_done(input int target, input int limit);
      int k = 0;
      while (done_cnt < target && k < limit) begin
         @(negedge clk);
         #2;
         k++;
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic run_xfer(input string name, input logic [AW-1:0] base, input logic [LW-1:0] len,
                           input int exp_act, input int exp_rd);
      int a0, r0, d0;
      a0 = act_cnt; r0 = rd_cnt; d0 = done_cnt;
      push_exp(base, fifo_seq, int'(len));
      start(base, len, 1'b0);
      wait_done(d0 + 1, 300);
      idle_cycles(3);
      check({name, "_done"}, done_cnt - d0, 1);
      check({name, "_active"}, act_cnt - a0, exp_act);
      check({name, "_rd"}, rd_cnt - r0, exp_rd);
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_err"}, dma_err_o, 0);
   endtask

   initial begin
      int a0, r0, d0, w0, k;

      // Reset state
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #2;
      check("rst_active", DMA_Active_o, 0);
      check("rst_done", ASSP_DMA_Done_o, 0);
      check("rst_wr", mem_wr_o, 0);
      check("rst_rd", fifo_rd_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_data", mem_data_o, 0);
      check("rst_err", dma_err_o, 0);
      check("rst_state", dbg_state_o, ST_IDLE);
      DMA_Enable_i = 1'b1;

      run_xfer("basic", 16'h0100, 10'd4, 12, 4);
      run_xfer("len0", 16'h0200, 10'd0, 1, 0);
      run_xfer("wrap", 16'hFFFE, 10'd3, 9, 3);

      // Memory stalls for 5 cycles on the second word.
      stall_word = wr_cnt + 1;
      stall_len  = 5;
      run_xfer("stall", 16'h0300, 10'd3, 14, 3);
      check("stall_cycles", stall_used, 5);

      // Request held high: a second transfer starts on return to IDLE.
      a0 = act_cnt; r0 = rd_cnt; d0 = done_cnt;
      push_exp(16'h0400, fifo_seq, 1);
      push_exp(16'h0400, fifo_seq + 1'b1, 1);
      start(16'h0400, 10'd1, 1'b1);
      wait_done(d0 + 2, 100);
      DMA_REQ_i = 1'b0;
      idle_cycles(4);
      check("hold_done", done_cnt - d0, 2);
      check("hold_active", act_cnt - a0, 6);
      check("hold_rd", rd_cnt - r0, 2);
      check("hold_left", exp_q.size(), 0);

      // Enable dropped while word 2 of 8 is being written.
      a0 = act_cnt; r0 = rd_cnt; d0 = done_cnt; w0 = wr_cnt;
      push_exp(16'h0500, fifo_seq, 2);
      start(16'h0500, 10'd8, 1'b0);
      k = 0;
      while (!(mem_wr_o && wr_cnt == w0 + 1) && k < 100) begin
         @(negedge clk);
         k++;
      end
      DMA_Enable_i = 1'b0;
      wait_done(d0 + 1, 50);
      idle_cycles(3);
      DMA_Enable_i = 1'b1;
      check("drop_done", done_cnt - d0, 1);
      check("drop_err", dma_err_o, 1);
      check("drop_rd", rd_cnt - r0, 2);
      check("drop_active", act_cnt - a0, 6);
      check("drop_left", exp_q.size(), 0);

      // Reset mid-transfer after two words: no Done, outputs cleared.
      d0 = done_cnt; w0 = wr_cnt;
      push_exp(16'h0600, fifo_seq, 2);
      start(16'h0600, 10'd8, 1'b0);
      #2;
      check("newreq_err_clr", dma_err_o, 0);
      k = 0;
      while (wr_cnt < w0 + 2 && k < 100) begin
         @(negedge clk);
         #2;
         k++;
      end
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      #2;
      check("mid_rst_active", DMA_Active_o, 0);
      check("mid_rst_wr", mem_wr_o, 0);
      check("mid_rst_rd", fifo_rd_o, 0);
      check("mid_rst_addr", mem_addr_o, 0);
      check("mid_rst_data", mem_data_o, 0);
      check("mid_rst_err", dma_err_o, 0);
      rst_i = 1'b0;
      idle_cycles(5);
      check("mid_rst_nodone", done_cnt - d0, 0);
      check("mid_rst_writes", wr_cnt - w0, 2);
      check("mid_rst_left", exp_q.size(), 0);

      // FIFO starved in POP.
      fifo_empty_i = 1'b1;
      a0 = act_cnt; r0 = rd_cnt; d0 = done_cnt;
      start(16'h0700, 10'd2, 1'b0);
`ifdef DMA_XFER_TIMEOUT_EN
      wait_done(d0 + 1, 1200);
      idle_cycles(2);
      check("tmo_done", done_cnt - d0, 1);
      check("tmo_err", dma_err_o, 1);
      check("tmo_active", act_cnt - a0, 1023);
`else
      idle_cycles(2000);
      check("starve_state", dbg_state_o, ST_POP);
      check("starve_active", DMA_Active_o, 1);
      check("starve_nodone", done_cnt - d0, 0);
      DMA_Enable_i = 1'b0;
      wait_done(d0 + 1, 20);
      idle_cycles(2);
      check("pop_abort_done", done_cnt - d0, 1);
      check("pop_abort_err", dma_err_o, 1);
      DMA_Enable_i = 1'b1;
`endif
      check("starve_rd", rd_cnt - r0, 0);
      fifo_empty_i = 1'b0;
      idle_cycles(3);

      check("active_done_overlap", overlap_cnt, 0);
      check("unexpected_writes", extra_wr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dma_xfer_engine.md
DMA_XFER_ENGINE -- requirements
Module: dma_xfer_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32, data word width.
- ADDR_W, 16, word address width.
- LEN_W, 10, transfer-length width.
- TMO_CYC, 1023, FIFO-starve timeout in cycles (timeout build only).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous active-high reset.
- DMA_Enable_i, in, 1, engine enable.
- DMA_REQ_i, in, 1, level request from peripheral.
- base_addr_i, in, ADDR_W, start word address.
- xfer_len_i, in, LEN_W, words per transfer.
- fifo_data_i, in, DATA_W, FIFO read data, valid the cycle after fifo_rd_o.
- fifo_empty_i, in, 1, FIFO empty.
- fifo_rd_o, out, 1, FIFO pop strobe.
- mem_wr_o, out, 1, memory write request.
- mem_addr_o, out, ADDR_W, write address.
- mem_data_o, out, DATA_W, write data.
- mem_ready_i, in, 1, write accepted this cycle.
- DMA_Active_o, out, 1, transfer in progress.
- ASSP_DMA_Done_o, out, 1, one-cycle completion pulse.
- dma_err_o, out, 1, sticky abort/timeout flag.

Function
REQ-003 FSM states: IDLE, POP, CAPT, WRITE, DONE.
REQ-004 IDLE: DMA_REQ_i=1 and DMA_Enable_i=1 sampled -> latch base_addr_i and xfer_len_i, next cycle DMA_Active_o=1, state POP; xfer_len_i=0 -> DONE directly.
REQ-005 POP: fifo_empty_i=0 -> fifo_rd_o=1 for exactly one cycle, go CAPT; empty -> wait in POP, no strobe.
REQ-006 CAPT: register fifo_data_i into mem_data_o, go WRITE.
REQ-007 WRITE: mem_wr_o held high with stable addr/data until mem_ready_i=1; on acceptance, address +1 and remaining count -1.
REQ-008 After acceptance: remaining count 0 -> DONE, else POP; minimum 3 cycles per word.
REQ-009 Address increments modulo 2^ADDR_W; 0xFFFF wraps to 0x0000 without error.
REQ-010 DONE: DMA_Active_o=0, ASSP_DMA_Done_o=1 for exactly one cycle, then IDLE.
REQ-011 DMA_REQ_i is ignored outside IDLE; a request still high on IDLE entry starts a new transfer.
REQ-012 DMA_Enable_i low in POP: go DONE immediately and set dma_err_o; in CAPT/WRITE, complete the current word first, then go DONE and set dma_err_o.
REQ-013 dma_err_o is cleared only on acceptance of a new request or by reset.
REQ-014 DMA_Active_o is high from the cycle after acceptance through the last WRITE cycle, and never high in the same cycle as ASSP_DMA_Done_o.

Reset
REQ-015 rst_i=1 at a clock edge -> state IDLE, and all outputs, counters and address register 0 on the next cycle.
REQ-016 Reset mid-transfer abandons the transfer with no Done pulse; a pending mem write is dropped.

Configuration
REQ-017 DMA_XFER_TIMEOUT_EN defined: in POP, TMO_CYC consecutive cycles with fifo_empty_i=1 -> DONE and set dma_err_o; the counter restarts on each pop.
REQ-018 DMA_XFER_TIMEOUT_EN undefined: POP waits indefinitely; no timeout counter is synthesized.

Structure
REQ-019 Shared package dma_pkg holds the FSM state enum and default widths (DATA_W, ADDR_W, LEN_W, TMO_CYC).
REQ-020 Sub-module dma_xfer_cnt holds the address/remaining-count registers with load and step; the FSM stays in dma_xfer_engine.

Verification
REQ-021 base=0x0100, len=4, FIFO always non-empty, mem_ready_i always 1 -> writes to 0x0100..0x0103 in order, 12 Active cycles, one Done pulse, err=0.
REQ-022 len=0 with request -> Active 1 cycle, Done pulse, no fifo_rd_o or mem_wr_o.
REQ-023 base=0xFFFE, len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-024 mem_ready_i low 5 cycles on word 2 -> addr/data stable throughout, no extra fifo_rd_o.
REQ-025 Enable dropped during WRITE of word 2 of 8 -> word 2 completes, Done pulse, err=1; rst_i mid-transfer -> no Done, all outputs 0.
REQ-026 Timeout build, FIFO empty for 1023 cycles in POP -> Done pulse and err=1; non-timeout build -> still in POP after 2000 cycles.
